// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the 5-stage MIPS pipeline.
// It accepts mult/multu/div/divu/mthi/mtlo from EX and runs multiply/divide
// for a fixed number of cycles. It owns the HI/LO registers and asks the
// hazard unit to stall ID while an MD-class instruction would collide with
// an operation that is running or starting.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic        cancel,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        id_is_md,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [31:0]      r_opA;
    logic [31:0]      r_opB;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic        w_idle;
    logic        w_start;
    logic        w_moveOk;
    logic        w_done;
    logic        w_isSigned;
    logic        w_isDiv;
    logic        w_negResult;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [63:0] w_prodMag;
    logic [63:0] w_prod;
    logic [31:0] w_divisor;
    logic [31:0] w_quotMag;
    logic [31:0] w_remMag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_resWrite;
    logic [31:0] w_resHi;
    logic [31:0] w_resLo;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_start  = md_valid & ~cancel & w_idle & (md_op >= OP_MULT) & (md_op <= OP_DIVU);
    assign w_moveOk = md_valid & ~cancel & w_idle;
    assign w_done   = (r_state == ST_RUN) & (r_cnt == CNT_W'(1));

    assign stall = id_is_md & (busy | w_start);
    assign busy  = (r_state == ST_RUN);
    assign hi    = r_hi;
    assign lo    = r_lo;

    // Signed ops are done on magnitudes with one shared unsigned multiplier
    // and divider; the signs are restored afterwards. This also makes
    // 0x80000000 / -1 wrap to 0x80000000 with remainder 0.
    assign w_isSigned  = (r_op == OP_MULT) | (r_op == OP_DIV);
    assign w_isDiv     = (r_op == OP_DIV) | (r_op == OP_DIVU);
    assign w_negResult = w_isSigned & (r_opA[31] ^ r_opB[31]);
    assign w_magA      = (w_isSigned & r_opA[31]) ? (~r_opA + 32'd1) : r_opA;
    assign w_magB      = (w_isSigned & r_opB[31]) ? (~r_opB + 32'd1) : r_opB;
    assign w_prodMag   = {32'h0, w_magA} * {32'h0, w_magB};
    assign w_prod      = w_negResult ? (~w_prodMag + 64'd1) : w_prodMag;
    assign w_divisor   = (w_magB == 32'd0) ? 32'd1 : w_magB;
    assign w_quotMag   = w_magA / w_divisor;
    assign w_remMag    = w_magA % w_divisor;
    assign w_quot      = w_negResult ? (~w_quotMag + 32'd1) : w_quotMag;
    assign w_rem       = (w_isSigned & r_opA[31]) ? (~w_remMag + 32'd1) : w_remMag;

    // Select the HI/LO result of the finishing op; a zero divisor writes nothing.
    always_comb begin
        w_resWrite = 1'b0;
        w_resHi    = r_hi;
        w_resLo    = r_lo;
        if (w_done) begin
            if (w_isDiv) begin
                if (r_opB != 32'd0) begin
                    w_resWrite = 1'b1;
                    w_resHi    = w_rem;
                    w_resLo    = w_quot;
                end
            end else begin
                w_resWrite = 1'b1;
                w_resHi    = w_prod[63:32];
                w_resLo    = w_prod[31:0];
            end
        end
    end

    // The FSM latches the op and its operands at start, then counts down the busy cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_opA   <= 32'd0;
            r_opB   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                        r_op    <= md_op;
                        r_opA   <= src_a;
                        r_opB   <= src_b;
                        if ((md_op == OP_MULT) || (md_op == OP_MULTU)) begin
                            r_cnt <= CNT_W'(MULT_CYCLES);
                        end else begin
                            r_cnt <= CNT_W'(DIV_CYCLES);
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Update HI/LO from a finishing op or from mthi/mtlo.
    // A result can only finish while running, and a move is only taken while
    // idle, so the two never compete for the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_resWrite) begin
            r_hi <= w_resHi;
            r_lo <= w_resLo;
        end else if (w_moveOk && (md_op == OP_MTHI)) begin
            r_hi <= src_a;
        end else if (w_moveOk && (md_op == OP_MTLO)) begin
            r_lo <= src_a;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: a directed, self-checking bench for md_sched. It drives
// inputs 1 time unit after each rising edge and samples outputs 1 unit
// after that.
module tb_md_sched;

    logic        clk;
    logic        reset;
    logic        md_valid;
    logic [2:0]  md_op;
    logic        cancel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        id_is_md;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    md_sched #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .md_valid(md_valid),
        .md_op   (md_op),
        .cancel  (cancel),
        .src_a   (src_a),
        .src_b   (src_b),
        .id_is_md(id_is_md),
        .stall   (stall),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    // Free-running clock; the first rising edge is at time 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Move to the next cycle: wait for the rising edge, then step 1 unit past it.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the EX/ID inputs for the current cycle.
    task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic cxl,
                                 input logic [31:0] a, input logic [31:0] b, input logic idMd);
        md_valid = valid;
        md_op    = op;
        cancel   = cxl;
        src_a    = a;
        src_b    = b;
        id_is_md = idMd;
        #1;
    endtask

    // Compare one observed value against its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);

        // Reset state
        nextCycle();
        nextCycle();
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        // Preload LO so the mid-run reset has something visible to clear
        applyStimulus(1'b1, OP_MTLO, 1'b0, 32'h55, 32'd0, 1'b0);
        nextCycle();
        checkOutput("mtlo_preload", lo, 32'h55);

        // A reset during RUN discards the mult 3*4
        applyStimulus(1'b1, OP_MULT, 1'b0, 32'd3, 32'd4, 1'b0);
        nextCycle();
        applyStimulus(1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput("rstrun_busy_t1", {31'd0, busy}, 32'd1);
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("rstrun_busy_t2", {31'd0, busy}, 32'd1);
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("rstrun_busy_t3", {31'd0, busy}, 32'd0);
        checkOutput("rstrun_lo_t3", lo, 32'd0);
        checkOutput("rstrun_hi_t3", hi, 32'd0);
        for (int k = 0; k < 8; k++) nextCycle();
        checkOutput("rstrun_lo_late", lo, 32'd0);
        checkOutput("rstrun_busy_late", {31'd0, busy}, 32'd0);

        // mult latency: -1 * 2, busy on T+1..T+5, result at T+6
        applyStimulus(1'b1, OP_MULT, 1'b0, 32'hFFFFFFFF, 32'd2, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            applyStimulus(1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
            checkOutput($sformatf("mult_busy_t%0d", k), {31'd0, busy}, 32'd1);
        end
        checkOutput("mult_lo_early", lo, 32'd0);
        nextCycle();
        checkOutput("mult_busy_t6", {31'd0, busy}, 32'd0);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFFE);

        // multu with the same operands
        applyStimulus(1'b1, OP_MULTU, 1'b0, 32'hFFFFFFFF, 32'd2, 1'b0);
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            applyStimulus(1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        checkOutput("multu_hi", hi, 32'h00000001);
        checkOutput("multu_lo", lo, 32'hFFFFFFFE);

        // Signed div -7/2 with id_is_md held: stall from T through T+10.
        // A cancel during the run must not stop the operation.
        applyStimulus(1'b1, OP_DIV, 1'b0, 32'hFFFFFFF9, 32'd2, 1'b1);
        checkOutput("div_stall_t0", {31'd0, stall}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            nextCycle();
            applyStimulus(1'b0, OP_NONE, (k == 3), 32'd0, 32'd0, 1'b1);
            checkOutput($sformatf("div_busy_t%0d", k), {31'd0, busy}, 32'd1);
            checkOutput($sformatf("div_stall_t%0d", k), {31'd0, stall}, 32'd1);
        end
        nextCycle();
        checkOutput("div_stall_t11", {31'd0, stall}, 32'd0);
        checkOutput("div_busy_t11", {31'd0, busy}, 32'd0);
        checkOutput("div_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_hi", hi, 32'hFFFFFFFF);

        // Divide by zero: busy for 10 cycles, HI/LO unchanged, no stall while id_is_md is 0
        applyStimulus(1'b1, OP_DIV, 1'b0, 32'd5, 32'd0, 1'b0);
        checkOutput("div0_stall_t0", {31'd0, stall}, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            nextCycle();
            applyStimulus(1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
            checkOutput($sformatf("div0_stall_t%0d", k), {31'd0, stall}, 32'd0);
        end
        checkOutput("div0_busy_t10", {31'd0, busy}, 32'd1);
        nextCycle();
        checkOutput("div0_busy_t11", {31'd0, busy}, 32'd0);
        checkOutput("div0_hi", hi, 32'hFFFFFFFF);
        checkOutput("div0_lo", lo, 32'hFFFFFFFD);

        // Overflow case 0x80000000 / -1
        applyStimulus(1'b1, OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        for (int k = 0; k < 11; k++) begin
            nextCycle();
            applyStimulus(1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        checkOutput("divovf_lo", lo, 32'h80000000);
        checkOutput("divovf_hi", hi, 32'h00000000);

        // Signed div 7 / -2: quotient -3, remainder +1 (sign follows the dividend)
        applyStimulus(1'b1, OP_DIV, 1'b0, 32'd7, 32'hFFFFFFFE, 1'b0);
        for (int k = 0; k < 11; k++) begin
            nextCycle();
            applyStimulus(1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        checkOutput("divneg_lo", lo, 32'hFFFFFFFD);
        checkOutput("divneg_hi", hi, 32'h00000001);

        // divu 0xFFFFFFF9 / 2 as unsigned values
        applyStimulus(1'b1, OP_DIVU, 1'b0, 32'hFFFFFFF9, 32'd2, 1'b0);
        for (int k = 0; k < 11; k++) begin
            nextCycle();
            applyStimulus(1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        checkOutput("divu_lo", lo, 32'h7FFFFFFC);
        checkOutput("divu_hi", hi, 32'h00000001);

        // A cancelled mult does not start
        applyStimulus(1'b1, OP_MULT, 1'b1, 32'd3, 32'd4, 1'b1);
        checkOutput("cxl_mult_stall", {31'd0, stall}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput("cxl_mult_busy", {31'd0, busy}, 32'd0);

        // A cancelled mtlo leaves LO unchanged; without cancel it writes next cycle
        applyStimulus(1'b1, OP_MTLO, 1'b1, 32'h1234, 32'd0, 1'b0);
        nextCycle();
        checkOutput("cxl_mtlo_lo", lo, 32'h7FFFFFFC);
        applyStimulus(1'b1, OP_MTLO, 1'b0, 32'h1234, 32'd0, 1'b0);
        nextCycle();
        checkOutput("mtlo_lo", lo, 32'h1234);
        checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);

        // mthi writes HI and never sets busy
        applyStimulus(1'b1, OP_MTHI, 1'b0, 32'hABCD0001, 32'd0, 1'b0);
        nextCycle();
        checkOutput("mthi_hi", hi, 32'hABCD0001);
        checkOutput("mthi_busy", {31'd0, busy}, 32'd0);

        // The reserved op is ignored
        applyStimulus(1'b1, OP_RSVD, 1'b0, 32'hDEAD0000, 32'd9, 1'b1);
        checkOutput("rsvd_stall", {31'd0, stall}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput("rsvd_busy", {31'd0, busy}, 32'd0);
        checkOutput("rsvd_hi", hi, 32'hABCD0001);
        checkOutput("rsvd_lo", lo, 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
